// File: rtl/vector_processor_pkg.sv
// Shared vector-processor definitions: CSR map, op/AVL encodings and vtype layout.
package vector_processor_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ELEN     = 32;
  localparam int unsigned VILL_BIT = XLEN - 1;

  localparam int unsigned VLMUL_LSB = 0;
  localparam int unsigned VSEW_LSB  = 3;
  localparam int unsigned VTA_BIT   = 6;
  localparam int unsigned VMA_BIT   = 7;

  typedef enum logic [1:0] {
    CSR_READ = 2'd0,
    CSRW     = 2'd1,
    CSRS     = 2'd2,
    CSRC     = 2'd3
  } csr_ops;

  typedef enum logic [1:0] {
    AVL_REG  = 2'd0,
    AVL_MAX  = 2'd1,
    AVL_KEEP = 2'd2
  } avl_modes;

  typedef enum logic [11:0] {
    CSR_VSTART = 12'h008,
    CSR_VXSAT  = 12'h009,
    CSR_VXRM   = 12'h00A,
    CSR_VCSR   = 12'h00F,
    CSR_VL     = 12'hC20,
    CSR_VTYPE  = 12'hC21,
    CSR_VLENB  = 12'hC22
  } csr_regs;

endpackage

// File: rtl/vector_csr_unit_if.sv
// Request/response bus between the scalar decoder (master) and the vector CSR unit (slave).
interface vector_csr_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_is_vset;
  logic [11:0]     req_addr;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] req_vtype;
  logic [1:0]      req_avl_mode;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_is_vset, req_addr, req_op, req_wdata, req_vtype, req_avl_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_is_vset, req_addr, req_op, req_wdata, req_vtype, req_avl_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/vlmax_calc.sv
// Combinational VLMAX and SEW/LMUL legality for a requested vtype.
module vlmax_calc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 256,
  parameter int unsigned ELEN = 32
) (
  input  logic [2:0]      vsew,
  input  logic [2:0]      vlmul,
  output logic [XLEN-1:0] vlmax,
  output logic            vill
);
  localparam int unsigned MAX_VSEW = $clog2(ELEN / 8);

  logic [XLEN-1:0] per_reg;
  logic            frac_bad;

  always_comb begin
    per_reg  = XLEN'(VLEN) >> (32'd3 + 32'(vsew));
    frac_bad = 1'b0;
    if (vlmul[2]) begin
      // Fractional LMUL: element must fit in LMUL*ELEN bits.
      vlmax    = per_reg >> (32'd8 - 32'(vlmul));
      frac_bad = (32'd8 << vsew) > (ELEN >> (32'd8 - 32'(vlmul)));
    end else begin
      vlmax = per_reg << vlmul;
    end
    vill = (32'(vsew) > MAX_VSEW) || (vlmul == 3'd4) || frac_bad;
  end
endmodule

// File: rtl/vector_csr_unit.sv
// Vector CSR/config unit: owns vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb and executes vset requests.
module vector_csr_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VLEN = 256,
  parameter int unsigned ELEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  vector_csr_unit_if.slave  bus,
  input  logic              vxsat_set,
  input  logic              vstart_wr,
  input  logic [XLEN-1:0]   vstart_wdata,
  output logic [XLEN-1:0]   vl_o,
  output logic [2:0]        vsew_o,
  output logic [2:0]        vlmul_o,
  output logic              vta_o,
  output logic              vma_o,
  output logic              vill_o,
  output logic [1:0]        vxrm_o,
  output logic [XLEN-1:0]   vstart_o
);
  import vector_processor_pkg::*;

  localparam int unsigned VSTART_W = $clog2(VLEN);
  localparam logic [XLEN-1:0] VTYPE_ILL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  state_e              state, state_nxt;
  logic [VSTART_W-1:0] vstart_q, vstart_d;
  logic                vxsat_q, vxsat_d;
  logic [1:0]          vxrm_q, vxrm_d;
  logic [XLEN-1:0]     vl_q, vl_d, vtype_q, vtype_d, rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                accept, known, read_only, writes, calc_vill;
  logic [XLEN-1:0]     vlmax, avl, old_val, new_val;
  csr_ops              op;
  logic                unused_bits;

  assign unused_bits = ^vstart_wdata[XLEN-1:VSTART_W];

  vlmax_calc #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) u_vlmax (
    .vsew  (bus.req_vtype[VSEW_LSB +: 3]),
    .vlmul (bus.req_vtype[VLMUL_LSB +: 3]),
    .vlmax (vlmax),
    .vill  (calc_vill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.req_valid) state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = bus.req_valid && (state == ST_IDLE);
    op        = csr_ops'(bus.req_op);
    vstart_d  = vstart_q;
    vxsat_d   = vxsat_q;
    vxrm_d    = vxrm_q;
    vl_d      = vl_q;
    vtype_d   = vtype_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    avl       = bus.req_wdata;
    old_val   = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (bus.req_addr)
      CSR_VSTART: old_val = XLEN'(vstart_q);
      CSR_VXSAT:  old_val = XLEN'(vxsat_q);
      CSR_VXRM:   old_val = XLEN'(vxrm_q);
      CSR_VCSR:   old_val = XLEN'({vxrm_q, vxsat_q});
      CSR_VL:     begin old_val = vl_q;            read_only = 1'b1; end
      CSR_VTYPE:  begin old_val = vtype_q;         read_only = 1'b1; end
      CSR_VLENB:  begin old_val = XLEN'(VLEN / 8); read_only = 1'b1; end
      default:    known = 1'b0;
    endcase
    // Set/clear with a zero mask is a pure read and never faults on read-only CSRs.
    writes = (op == CSRW) || (((op == CSRS) || (op == CSRC)) && (|bus.req_wdata));
    unique case (op)
      CSRW:    new_val = bus.req_wdata;
      CSRS:    new_val = old_val | bus.req_wdata;
      CSRC:    new_val = old_val & ~bus.req_wdata;
      default: new_val = old_val;
    endcase

    if (accept) begin
      if (bus.req_is_vset) begin
        if (calc_vill || (|bus.req_vtype[XLEN-2:8])) begin
          vtype_d = VTYPE_ILL;
          vl_d    = '0;
        end else begin
          case (bus.req_avl_mode)
            AVL_MAX:  avl = vlmax;
            AVL_KEEP: avl = vl_q;
            default:  avl = bus.req_wdata;
          endcase
          vl_d    = (avl < vlmax) ? avl : vlmax;
          vtype_d = bus.req_vtype;
        end
        vstart_d = '0;
        rdata_d  = vl_d;
        err_d    = 1'b0;
      end else begin
        rdata_d = known ? old_val : '0;
        err_d   = !known || (read_only && writes);
        if (known && !read_only && writes) begin
          case (bus.req_addr)
            CSR_VSTART: vstart_d = new_val[VSTART_W-1:0];
            CSR_VXSAT:  vxsat_d  = new_val[0];
            CSR_VXRM:   vxrm_d   = new_val[1:0];
            CSR_VCSR:   begin vxrm_d = new_val[2:1]; vxsat_d = new_val[0]; end
            default:    ;
          endcase
        end
      end
    end

    vxsat_d = vxsat_d | vxsat_set;
    if (vstart_wr) vstart_d = vstart_wdata[VSTART_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vstart_q <= '0;
      vxsat_q  <= 1'b0;
      vxrm_q   <= '0;
      vl_q     <= '0;
      vtype_q  <= VTYPE_ILL;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      vstart_q <= vstart_d;
      vxsat_q  <= vxsat_d;
      vxrm_q   <= vxrm_d;
      vl_q     <= vl_d;
      vtype_q  <= vtype_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign vl_o     = vl_q;
  assign vsew_o   = vtype_q[VSEW_LSB +: 3];
  assign vlmul_o  = vtype_q[VLMUL_LSB +: 3];
  assign vta_o    = vtype_q[VTA_BIT];
  assign vma_o    = vtype_q[VMA_BIT];
  assign vill_o   = vtype_q[XLEN-1];
  assign vxrm_o   = vxrm_q;
  assign vstart_o = XLEN'(vstart_q);
endmodule

// File: tb/tb_vector_csr_unit.sv
// Bench for vector_csr_unit: directed vector table, hold/reset sequences, random vs reference model.
module tb_vector_csr_unit;
  localparam int unsigned VLEN = 256;
  localparam int unsigned ELEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vxsat_set = 1'b0;
  logic        vstart_wr = 1'b0;
  logic [31:0] vstart_wdata = '0;
  logic [31:0] vl_o, vstart_o;
  logic [2:0]  vsew_o, vlmul_o;
  logic        vta_o, vma_o, vill_o;
  logic [1:0]  vxrm_o;

  vector_csr_unit_if #(.XLEN(32)) bus ();

  vector_csr_unit #(.XLEN(32), .VLEN(VLEN), .ELEN(ELEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .vxsat_set(vxsat_set), .vstart_wr(vstart_wr), .vstart_wdata(vstart_wdata),
    .vl_o(vl_o), .vsew_o(vsew_o), .vlmul_o(vlmul_o), .vta_o(vta_o), .vma_o(vma_o),
    .vill_o(vill_o), .vxrm_o(vxrm_o), .vstart_o(vstart_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_vset;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] vtype;
    logic [1:0]  mode;
    logic        sat;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_vl;
    logic        e_vill;
    logic [1:0]  e_vxrm;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned m_vstart, m_vxsat, m_vxrm, m_vl;
  logic [31:0] m_vtype;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [11:0] a, logic [1:0] op, logic [31:0] wd,
                              logic [31:0] vt, logic [1:0] md, logic s, logic [31:0] er,
                              logic ee, logic [31:0] evl, logic evill, logic [1:0] evxrm);
    vec_t r;
    r.is_vset = v; r.addr = a; r.op = op; r.wdata = wd; r.vtype = vt; r.mode = md; r.sat = s;
    r.e_rdata = er; r.e_err = ee; r.e_vl = evl; r.e_vill = evill; r.e_vxrm = evxrm;
    return r;
  endfunction

  task automatic drive_req(input vec_t r);
    bus.req_is_vset  = r.is_vset;
    bus.req_addr     = r.addr;
    bus.req_op       = r.op;
    bus.req_wdata    = r.wdata;
    bus.req_vtype    = r.vtype;
    bus.req_avl_mode = r.mode;
    vxsat_set        = r.sat;
    bus.req_valid    = 1'b1;
  endtask

  task automatic transact(input vec_t r, output logic [31:0] rd, output logic er);
    int unsigned guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    drive_req(r);
    @(negedge clk);
    bus.req_valid = 1'b0;
    vxsat_set     = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  // Reference model: architectural CSR semantics expressed with plain integer arithmetic.
  task automatic model_req(input vec_t r, output logic [31:0] er, output logic ee);
    int unsigned old_v, new_v, vsew, vlmul, sew, num, den, vlmax, avl;
    bit known, ro, wr, legal;
    er = 0; ee = 0;
    if (r.is_vset) begin
      vsew  = (r.vtype >> 3) & 7;
      vlmul = r.vtype & 7;
      sew   = 8 << vsew;
      if (vlmul < 4) begin num = 1 << vlmul; den = 1; end
      else begin num = 1; den = 1 << (8 - vlmul); end
      legal = (sew <= ELEN) && (vlmul != 4) && (r.vtype[30:8] == 0) && (sew * den <= ELEN * num);
      if (!legal) begin
        m_vtype = 32'h8000_0000;
        m_vl = 0;
      end else begin
        vlmax = VLEN * num / (sew * den);
        avl = (r.mode == 1) ? vlmax : (r.mode == 2) ? m_vl : r.wdata;
        m_vl = (avl < vlmax) ? avl : vlmax;
        m_vtype = r.vtype;
      end
      m_vstart = 0;
      er = m_vl;
    end else begin
      known = 1; ro = 0; old_v = 0;
      case (r.addr)
        12'h008: old_v = m_vstart;
        12'h009: old_v = m_vxsat;
        12'h00A: old_v = m_vxrm;
        12'h00F: old_v = m_vxrm * 2 + m_vxsat;
        12'hC20: begin old_v = m_vl; ro = 1; end
        12'hC21: begin old_v = m_vtype; ro = 1; end
        12'hC22: begin old_v = VLEN / 8; ro = 1; end
        default: known = 0;
      endcase
      wr = (r.op == 1) || (r.op != 0 && r.wdata != 0);
      new_v = (r.op == 1) ? r.wdata : (r.op == 2) ? (old_v | r.wdata) : (old_v & ~r.wdata);
      if (!known) begin
        er = 0; ee = 1;
      end else begin
        er = old_v;
        ee = ro && wr;
        if (!ro && wr) begin
          case (r.addr)
            12'h008: m_vstart = new_v % VLEN;
            12'h009: m_vxsat = new_v & 1;
            12'h00A: m_vxrm = new_v & 3;
            default: begin m_vxrm = (new_v >> 1) & 3; m_vxsat = new_v & 1; end
          endcase
        end
      end
    end
    if (r.sat) m_vxsat = 1;
  endtask

  vec_t        tbl[26];
  logic [11:0] addrs[7] = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22};

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, rd0, er32;
    logic        er;
    vec_t        r;

    bus.req_valid = 0; bus.req_is_vset = 0; bus.req_addr = '0; bus.req_op = '0;
    bus.req_wdata = '0; bus.req_vtype = '0; bus.req_avl_mode = '0; bus.rsp_ready = 0;

    //        vset addr     op  wdata    vtype   md sat  rdata          err vl   vill vxrm
    tbl[0]  = mk(0, 12'hC22, 0, 0,       0,      0, 0,  32,            0,  0,   1,   0);
    tbl[1]  = mk(0, 12'hC21, 0, 0,       0,      0, 0,  32'h8000_0000, 0,  0,   1,   0);
    tbl[2]  = mk(0, 12'h008, 1, 5,       0,      0, 0,  0,             0,  0,   1,   0);
    tbl[3]  = mk(1, 12'h000, 0, 100,     32'h11, 0, 0,  16,            0,  16,  0,   0);
    tbl[4]  = mk(0, 12'h008, 0, 0,       0,      0, 0,  0,             0,  16,  0,   0);
    tbl[5]  = mk(1, 12'h000, 0, 10,      32'h18, 0, 0,  0,             0,  0,   1,   0);
    tbl[6]  = mk(0, 12'hC21, 0, 0,       0,      0, 0,  32'h8000_0000, 0,  0,   1,   0);
    tbl[7]  = mk(1, 12'h000, 0, 10,      32'h04, 0, 0,  0,             0,  0,   1,   0);
    tbl[8]  = mk(1, 12'h000, 0, 5,       32'h03, 1, 0,  256,           0,  256, 0,   0);
    tbl[9]  = mk(1, 12'h000, 0, 3,       32'h0B, 2, 0,  128,           0,  128, 0,   0);
    tbl[10] = mk(0, 12'h00F, 1, 5,       0,      0, 0,  0,             0,  128, 0,   2);
    tbl[11] = mk(0, 12'h009, 0, 0,       0,      0, 0,  1,             0,  128, 0,   2);
    tbl[12] = mk(0, 12'h009, 3, 1,       0,      0, 1,  1,             0,  128, 0,   2);
    tbl[13] = mk(0, 12'h009, 0, 0,       0,      0, 0,  1,             0,  128, 0,   2);
    tbl[14] = mk(0, 12'hC20, 1, 7,       0,      0, 0,  128,           1,  128, 0,   2);
    tbl[15] = mk(0, 12'hC22, 2, 0,       0,      0, 0,  32,            0,  128, 0,   2);
    tbl[16] = mk(0, 12'h123, 0, 0,       0,      0, 0,  0,             1,  128, 0,   2);
    tbl[17] = mk(0, 12'h00A, 1, 3,       0,      0, 0,  2,             0,  128, 0,   3);
    tbl[18] = mk(0, 12'h00F, 0, 0,       0,      0, 0,  7,             0,  128, 0,   3);
    tbl[19] = mk(0, 12'h008, 1, 32'h1FF, 0,      0, 0,  0,             0,  128, 0,   3);
    tbl[20] = mk(0, 12'h008, 0, 0,       0,      0, 0,  32'hFF,        0,  128, 0,   3);
    tbl[21] = mk(0, 12'h00F, 3, 6,       0,      0, 0,  7,             0,  128, 0,   0);
    tbl[22] = mk(0, 12'h00F, 0, 0,       0,      0, 0,  1,             0,  128, 0,   0);
    tbl[23] = mk(1, 12'h000, 0, 5,       32'h0F, 0, 0,  5,             0,  5,   0,   0);
    tbl[24] = mk(1, 12'h000, 0, 5,       32'h17, 0, 0,  0,             0,  0,   1,   0);
    tbl[25] = mk(1, 12'h000, 0, 100,     32'h111,0, 0,  0,             0,  0,   1,   0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_rsp_err", 32'(bus.rsp_err), 0);
    check("reset_vill", 32'(vill_o), 1);
    check("reset_vl", vl_o, 0);
    check("reset_vstart", vstart_o, 0);

    for (int i = 0; i < 26; i++) begin
      transact(tbl[i], rd, er);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].e_rdata);
      check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].e_err));
      check($sformatf("tbl%0d_vl", i), vl_o, tbl[i].e_vl);
      check($sformatf("tbl%0d_vill", i), 32'(vill_o), 32'(tbl[i].e_vill));
      check($sformatf("tbl%0d_vxrm", i), 32'(vxrm_o), 32'(tbl[i].e_vxrm));
    end

    // Response held under back-pressure.
    @(negedge clk);
    drive_req(mk(0, 12'hC22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    bus.req_valid = 1'b0;
    rd0 = bus.rsp_rdata;
    check("hold_rdata", rd0, 32);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_req_ready", 32'(bus.req_ready), 0);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 1);
      check("hold_rsp_rdata", bus.rsp_rdata, 32);
      check("hold_rsp_err", 32'(bus.rsp_err), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("hold_release_ready", 32'(bus.req_ready), 1);

    // Reset arriving mid-response drops it asynchronously.
    transact(mk(1, 12'h000, 0, 0, 32'h03, 1, 0, 0, 0, 0, 0, 0), rd, er);
    check("pre_reset_vl", vl_o, 256);
    @(negedge clk);
    drive_req(mk(0, 12'hC21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_rsp_valid", 32'(bus.rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(bus.rsp_valid), 0);
    check("async_req_ready", 32'(bus.req_ready), 1);
    check("async_vl", vl_o, 0);
    check("async_vill", 32'(vill_o), 1);
    @(negedge clk);
    rst_n = 1'b1;

    m_vstart = 0; m_vxsat = 0; m_vxrm = 0; m_vl = 0; m_vtype = 32'h8000_0000;

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
          vstart_wr = 1'b1;
          vstart_wdata = $urandom;
          m_vstart = vstart_wdata % VLEN;
        end else begin
          vxsat_set = 1'b1;
          m_vxsat = 1;
        end
        @(negedge clk);
        vstart_wr = 1'b0;
        vxsat_set = 1'b0;
        check("rnd_idle_vstart", vstart_o, m_vstart);
      end
      r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      r.is_vset = ($urandom_range(0, 2) == 0);
      r.addr = ($urandom_range(0, 7) == 7) ? 12'($urandom) : addrs[$urandom_range(0, 6)];
      r.op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       r.wdata = 0;
        1:       r.wdata = $urandom;
        default: r.wdata = $urandom_range(0, 300);
      endcase
      r.vtype = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) r.vtype[5] = 1'b0;
      if ($urandom_range(0, 9) == 0) r.vtype[$urandom_range(8, 30)] = 1'b1;
      r.mode = 2'($urandom_range(0, 2));
      r.sat = ($urandom_range(0, 4) == 0);
      model_req(r, rd0, er);
      er32 = 32'(er);
      transact(r, rd, er);
      check("rnd_rdata", rd, rd0);
      check("rnd_err", 32'(er), er32);
      check("rnd_vl", vl_o, m_vl);
      check("rnd_vtype", {23'd0, vill_o, vma_o, vta_o, vsew_o, vlmul_o}, {23'd0, m_vtype[31], m_vtype[7:0]});
      check("rnd_vxrm", 32'(vxrm_o), m_vxrm);
      check("rnd_vstart", vstart_o, m_vstart);
    end

    r = mk(0, 12'h009, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_req(r, rd0, er);
    transact(r, rd, er);
    check("final_vxsat", rd, rd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
